// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - Default register addresses inside the data-memory window
//   - Transmit FSM state encoding
//   - Bit positions of the status word
package mmio_pkg;

    localparam logic [12:0] DATA_ADDR = 13'h1F00;
    localparam logic [12:0] STAT_ADDR = 13'h1F04;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-port view of the peripheral window.
//   wena  : store strobe             (CPU -> peripheral)
//   addr  : byte address [12:0]      (CPU -> peripheral)
//   wdata : store data               (CPU -> peripheral)
//   sel   : address hits the window  (peripheral -> CPU, gates dmem write)
//   rdata : read data                (peripheral -> CPU)
interface mmio_uart_tx_if;
    logic        wena;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;

    modport master (output wena, addr, wdata, input  sel, rdata);
    modport slave  (input  wena, addr, wdata, output sel, rdata);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Byte-wide synchronous FIFO with asynchronous active-high reset.
//   clock, reset      : clock, async reset (empties the FIFO)
//   push_i/push_data_i: write request and byte; ignored when full
//   pop_i             : read request; ignored when empty
//   pop_data_o        : head byte (valid while !empty_o)
//   full_o, empty_o   : occupancy flags, derived from a count one bit wider
//                       than the pointers so both states are distinct
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] pop_data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == {CW{1'b0}});
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_ok_s  = push_i && !full_o;
    assign pop_ok_s   = pop_i && !empty_o;

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside the data memory.
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : CPU data port (slave side); sel/rdata are combinational
//   txd          : registered serial output, idles high
//   busy         : registered, high while a frame is in progress
// Stores to DATA_ADDR queue a byte (dropped and flagged when the FIFO is full);
// stores to STAT_ADDR with wdata[0]=1 clear the sticky overflow flag.
// Status word: {28'b0, overflow, busy, full, empty}.
module mmio_uart_tx #(
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [12:0] DATA_ADDR  = mmio_pkg::DATA_ADDR,
    parameter logic [12:0] STAT_ADDR  = mmio_pkg::STAT_ADDR
) (
    input  logic            clock,
    input  logic            reset,
    mmio_uart_tx_if.slave   bus,
    output logic            txd,
    output logic            busy
);
    import mmio_pkg::*;

    localparam int BW = $clog2(CLK_DIV);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic          sel_data_s, sel_stat_s;
    logic          push_req_s, clear_s, pop_s, baud_end_s;
    logic          full_s, empty_s;
    logic [7:0]    head_s;
    logic [31:0]   status_s;
    logic          unused_wdata_s;

    assign sel_data_s     = (bus.addr == DATA_ADDR);
    assign sel_stat_s     = (bus.addr == STAT_ADDR);
    assign push_req_s     = bus.wena && sel_data_s;
    assign clear_s        = bus.wena && sel_stat_s && bus.wdata[0];
    assign baud_end_s     = (baud_q == BW'(CLK_DIV - 1));
    assign unused_wdata_s = ^bus.wdata[31:8];

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_req_s),
        .push_data_i (bus.wdata[7:0]),
        .pop_i       (pop_s),
        .pop_data_o  (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    // Status word assembly and window read mux.
    always_comb begin
        status_s           = 32'h0;
        status_s[ST_EMPTY] = empty_s;
        status_s[ST_FULL]  = full_s;
        status_s[ST_BUSY]  = busy_q;
        status_s[ST_OVF]   = ovf_q;
    end

    assign bus.sel   = sel_data_s | sel_stat_s;
    assign bus.rdata = sel_stat_s ? status_s : 32'h0;

    // Sticky overflow: a refused push on the same edge as a clear wins.
    always_comb begin
        if (push_req_s && full_s) begin
            ovf_d = 1'b1;
        end else if (clear_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // FSM state, baud/bit counters and shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; pops happen from IDLE or at the end of STOP so
    // consecutive frames run with no idle gap.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    baud_d  = {BW{1'b0}};
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    baud_d  = {BW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so txd/busy align with state_q.
    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Registered serial line and busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            txd_q  <= txd_d;
            busy_q <= busy_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
    import mmio_pkg::*;

    logic clock;
    logic reset;
    logic txd;
    logic busy;
    int   errors;
    int   checks;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .CLK_DIV    (4),
        .FIFO_DEPTH (8),
        .DATA_ADDR  (DATA_ADDR),
        .STAT_ADDR  (STAT_ADDR)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // Expected line level at bit slot pos (0=start, 1..8=data LSB first, 9=stop).
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        bus.wena  = 1'b0;
        bus.addr  = STAT_ADDR;
        bus.wdata = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL reset_rdata: got %h expected 00000001", bus.rdata); end
        checks++; if (bus.sel !== 1'b1) begin errors++; $display("FAIL reset_sel: got %b expected 1", bus.sel); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_single_byte();
        bus.wena  = 1'b1;
        bus.addr  = DATA_ADDR;
        bus.wdata = 32'h000000A5;
        @(posedge clock); #1;
        bus.wena = 1'b0;
        bus.addr = STAT_ADDR;
        #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL single_queued_status: got %h expected 00000000", bus.rdata); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            checks++;
            if (txd !== frame_bit(8'hA5, i / 4)) begin
                errors++; $display("FAIL single_txd cycle %0d: got %b expected %b", i, txd, frame_bit(8'hA5, i / 4));
            end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b expected 1", busy); end
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL single_rdata_idle: got %h expected 00000001", bus.rdata); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        for (int c = 0; c < 362; c++) begin
            if (c < 10) begin
                bus.wena  = 1'b1;
                bus.addr  = DATA_ADDR;
                bus.wdata = 32'(c + 1);
            end else begin
                bus.wena = 1'b0;
                bus.addr = STAT_ADDR;
            end
            @(posedge clock); #1;
            if (c >= 1 && c <= 360) begin
                b = 8'((c - 1) / 40 + 1);
                checks++;
                if (txd !== frame_bit(b, ((c - 1) % 40) / 4)) begin
                    errors++; $display("FAIL ovf_txd sample %0d byte %h: got %b expected %b", c - 1, b, txd, frame_bit(b, ((c - 1) % 40) / 4));
                end
            end
            if (c == 9) begin
                bus.wena = 1'b0;
                bus.addr = STAT_ADDR;
                #1;
                checks++; if (bus.rdata !== 32'hE) begin errors++; $display("FAIL ovf_status: got %h expected 0000000e", bus.rdata); end
            end
        end
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL ovf_txd_idle: got %b expected 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_idle: got %b expected 0", busy); end
        checks++; if (bus.rdata !== 32'h9) begin errors++; $display("FAIL ovf_status_idle: got %h expected 00000009", bus.rdata); end
    endtask

    task automatic test_clear();
        bus.wena  = 1'b1;
        bus.addr  = STAT_ADDR;
        bus.wdata = 32'h1;
        #1;
        checks++; if (bus.sel !== 1'b1) begin errors++; $display("FAIL clear_sel: got %b expected 1", bus.sel); end
        @(posedge clock); #1;
        bus.wena  = 1'b0;
        bus.wdata = 32'h0;
        #1;
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL clear_status: got %h expected 00000001", bus.rdata); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bytes [3];
        bytes[0] = 8'h55; bytes[1] = 8'h33; bytes[2] = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            bus.wena  = 1'b1;
            bus.addr  = DATA_ADDR;
            bus.wdata = {24'h0, bytes[i]};
            @(posedge clock); #1;
        end
        bus.wena = 1'b0;
        bus.addr = STAT_ADDR;
        // First pop on the edge after the first store; data bit 3 starts 16 edges later.
        repeat (16) @(posedge clock);
        #2;
        checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midreset_bit3: got %b expected 0", txd); end
        reset = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midreset_txd: got %b expected 1", txd); end
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL midreset_status: got %h expected 00000001", bus.rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midreset_idle cycle %0d: got %b expected 1", i, txd); end
        end
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL midreset_after: got %h expected 00000001", bus.rdata); end
    endtask

    task automatic test_non_window();
        bus.wena  = 1'b1;
        bus.addr  = 13'h0040;
        bus.wdata = 32'h000000FF;
        #1;
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL nowin_sel: got %b expected 0", bus.sel); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL nowin_rdata: got %h expected 00000000", bus.rdata); end
        @(posedge clock); #1;
        bus.wena = 1'b0;
        bus.addr = STAT_ADDR;
        #1;
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL nowin_status: got %h expected 00000001", bus.rdata); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            checks++; if (txd !== 1'b1) begin errors++; $display("FAIL nowin_txd cycle %0d: got %b expected 1", i, txd); end
        end
    endtask

    initial begin
        clock  = 1'b0;
        errors = 0;
        checks = 0;
        test_reset();
        test_single_byte();
        test_overflow();
        test_clear();
        test_reset_mid_frame();
        test_non_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
